// File: rtl/fb_delay_est_pkg.sv
// Shared types for the DPD feedback loop-delay estimator.
package fb_delay_est_pkg;

    typedef logic signed [19:0] s20;
    typedef logic        [19:0] u20;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_TX,
        WAIT_FB,
        FIN
    } fb_est_state_t;

    localparam int FB_EST_MAX_LAG_DEF = 1023;

endpackage

// File: rtl/fb_delay_est_mag.sv
// Registered magnitude approximation: max(|I|,|Q|) + min(|I|,|Q|)/2, one cycle latency.
module mag_approx
    import fb_delay_est_pkg::*;
(
    input  logic clk,
    input  s20   i,
    input  s20   q,
    output u20   mag
);

    u20 ai, aq, mx, mn;

    // |-2^19| maps to 2^19, which still fits in the unsigned 20-bit result
    always_comb begin
        ai = i[19] ? u20'(-i) : u20'(i);
        aq = q[19] ? u20'(-q) : u20'(q);
        mx = (ai >= aq) ? ai : aq;
        mn = (ai >= aq) ? aq : ai;
    end

    always_ff @(posedge clk) begin
        mag <= mx + (mn >> 1);
    end

endmodule

// File: rtl/fb_delay_est.sv
// Loop-delay estimator: counts cycles from a rising tx magnitude crossing to the same
// crossing on the PA feedback path.
module fb_delay_est
    import fb_delay_est_pkg::*;
#(
    parameter int W       = 20,
    parameter int CW      = 12,
    parameter int MAX_LAG = FB_EST_MAX_LAG_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  threshold,
    input  logic [W-1:0]  tx_i,
    input  logic [W-1:0]  tx_q,
    input  logic [W-1:0]  fb_i,
    input  logic [W-1:0]  fb_q,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] delay_est,
    output logic          delay_valid
);

    fb_est_state_t state, state_nx;
    u20            tx_mag, fb_mag;
    logic [W-1:0]  thr_reg;
    logic [CW-1:0] wait_cnt, lag_cnt;
    logic          tx_hit, fb_hit, wait_last, lag_last;
    logic          accept, fin_done, fin_to;

    mag_approx u_tx_mag (.clk(clk), .i(tx_i), .q(tx_q), .mag(tx_mag));
    mag_approx u_fb_mag (.clk(clk), .i(fb_i), .q(fb_q), .mag(fb_mag));

    assign tx_hit    = (tx_mag >= thr_reg);
    assign fb_hit    = (fb_mag >= thr_reg);
    assign wait_last = ((wait_cnt + CW'(1)) == CW'(MAX_LAG));
    assign lag_last  = ((lag_cnt + CW'(1)) == CW'(MAX_LAG));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        fin_done = 1'b0;
        fin_to   = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept   = 1'b1;
                state_nx = ARM;
            end
            // require tx below threshold first so only a true rising edge is timed
            ARM: begin
                if (!tx_hit)        state_nx = WAIT_TX;
                else if (wait_last) begin fin_to = 1'b1; state_nx = FIN; end
            end
            WAIT_TX: begin
                if (tx_hit)         state_nx = WAIT_FB;
                else if (wait_last) begin fin_to = 1'b1; state_nx = FIN; end
            end
            WAIT_FB: begin
                if (fb_hit)         begin fin_done = 1'b1; state_nx = FIN; end
                else if (lag_last)  begin fin_to = 1'b1; state_nx = FIN; end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            delay_est   <= '0;
            delay_valid <= 1'b0;
            thr_reg     <= '0;
            wait_cnt    <= '0;
            lag_cnt     <= '0;
        end else begin
            done    <= fin_done;
            timeout <= fin_to;
            if (accept) begin
                thr_reg     <= threshold;
                delay_valid <= 1'b0;
                busy        <= 1'b1;
            end
            // watchdog restarts on every state change
            if (state_nx != state)
                wait_cnt <= '0;
            else if (state == ARM || state == WAIT_TX)
                wait_cnt <= wait_cnt + CW'(1);
            if (state == WAIT_TX && tx_hit)
                lag_cnt <= '0;
            else if (state == WAIT_FB)
                lag_cnt <= lag_cnt + CW'(1);
            if (fin_done) begin
                delay_est   <= lag_cnt + CW'(1);
                delay_valid <= 1'b1;
            end
            if (fin_done || fin_to)
                busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fb_delay_est.sv
// Bench for fb_delay_est: single-pulse tx stream, fb is tx through a delay line.
module tb_fb_delay_est;

    localparam int W       = 20;
    localparam int CW      = 12;
    localparam int MAX_LAG = 1023;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  threshold = '0;
    logic [W-1:0]  tx_i = '0, tx_q = '0, fb_i = '0, fb_q = '0;
    logic          busy, done, timeout, delay_valid;
    logic [CW-1:0] delay_est;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pulse_cyc = -100000;
    int dly = 0;
    int pi = 0, pq = 0;
    int exp_est = 0;

    always #5 clk = ~clk;

    fb_delay_est #(.W(W), .CW(CW), .MAX_LAG(MAX_LAG)) dut (
        .clk(clk), .reset(reset), .start(start), .threshold(threshold),
        .tx_i(tx_i), .tx_q(tx_q), .fb_i(fb_i), .fb_q(fb_q),
        .busy(busy), .done(done), .timeout(timeout),
        .delay_est(delay_est), .delay_valid(delay_valid)
    );

    // Sample stream: zero except one pulse on tx at pulse_cyc, and on fb dly samples later
    initial begin : drv
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            tx_i = (cyc == pulse_cyc) ? W'(pi) : '0;
            tx_q = (cyc == pulse_cyc) ? W'(pq) : '0;
            fb_i = (cyc == pulse_cyc + dly) ? W'(pi) : '0;
            fb_q = (cyc == pulse_cyc + dly) ? W'(pq) : '0;
        end
    end

    function automatic int mag_ref(input int i, input int q);
        int a, b;
        a = (i < 0) ? -i : i;
        b = (q < 0) ? -q : q;
        return (a > b) ? a + b / 2 : b + a / 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_timeout"}, 32'(timeout), 0);
        check({tag, "_valid"}, 32'(delay_valid), 0);
        check({tag, "_est"}, 32'(delay_est), 0);
    endtask

    // One measurement; rst_at / restart_at inject a reset or a stray start at loop step k
    task automatic meas(input int thr, input int ai, input int aq, input int d,
                        input int rst_at, input int restart_at);
        int  n_done, n_to, t_ev, est, p0;
        bit  crosses, exp_done;
        crosses  = (thr > 0) && (mag_ref(ai, aq) >= thr);
        exp_done = crosses && (d >= 1) && (d <= MAX_LAG);
        @(negedge clk);
        pi = ai; pq = aq; dly = d;
        pulse_cyc = cyc + 10;
        p0 = pulse_cyc;
        threshold = W'(thr);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        n_done = 0; n_to = 0; t_ev = -1; est = -1;
        for (int k = 0; k < 3000; k++) begin
            if (k == restart_at) begin
                threshold = 1;
                start = 1'b1;
            end
            if (k == rst_at) reset = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (k == rst_at) begin
                reset = 1'b0;
                pulse_cyc = -100000;
                exp_est = 0;
                check_idle_zero("mid_reset");
                return;
            end
            if (done) begin
                n_done++;
                if (t_ev < 0) t_ev = cyc;
                est = int'(delay_est);
            end
            if (timeout) begin
                n_to++;
                if (t_ev < 0) t_ev = cyc;
            end
            if (t_ev >= 0 && cyc > t_ev + 3) break;
        end
        pulse_cyc = -100000;
        check("event_seen", 32'(t_ev >= 0), 1);
        check("busy_after_fin", 32'(busy), 0);
        if (exp_done) begin
            check("done_count", 32'(n_done), 1);
            check("timeout_count", 32'(n_to), 0);
            check("delay_est", 32'(est), 32'(d));
            check("delay_valid_set", 32'(delay_valid), 1);
            check("done_latency", 32'((t_ev - p0 - d) >= 1 && (t_ev - p0 - d) <= 4), 1);
            exp_est = d;
        end else begin
            check("timeout_count", 32'(n_to), 1);
            check("done_count", 32'(n_done), 0);
            check("delay_est_held", 32'(delay_est), 32'(exp_est));
            check("delay_valid_clr", 32'(delay_valid), 0);
            if (crosses)
                check("timeout_latency",
                      32'((t_ev - p0) >= MAX_LAG && (t_ev - p0) <= MAX_LAG + 4), 1);
        end
    endtask

    initial begin : main
        int thr, ai, aq, d;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        meas(50000, 100000, 0, 500, -1, -1);        // basic 500-cycle delay
        meas(50000, 100000, 0, 1500, -1, -1);       // beyond MAX_LAG: timeout, est held
        meas(524288, -524288, 0, 1, -1, -1);        // full-scale crossing, D = 1
        meas(50000, 100000, 0, 500, 300, -1);       // reset mid WAIT_FB
        meas(50000, 100000, 0, 500, -1, -1);
        meas(50000, 100000, 0, 500, -1, 50);        // stray start while busy
        meas(0, 100000, 0, 500, -1, -1);            // zero threshold: ARM timeout
        meas(50000, 100000, 0, 500, -1, -1);
        meas(1000, 0, -3000, MAX_LAG, -1, -1);      // largest measurable delay
        meas(1000, 3000, 1500, MAX_LAG + 1, -1, -1);

        for (int n = 0; n < 6; n++) begin
            thr = int'($urandom_range(1, 600000));
            ai  = int'($urandom_range(0, 1048575)) - 524288;
            aq  = int'($urandom_range(0, 1048575)) - 524288;
            d   = int'($urandom_range(1, MAX_LAG));
            meas(thr, ai, aq, d, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
